// File: rtl/parking_lane_detector.sv
// parking_lane_detector
//   Front end for parking_fsm: debounces the street-side (A) and lot-side (B)
//   infrared beams and follows the A/B blocking order to find the direction
//   of travel. Each completed pass gives a one-cycle entry_sensor or
//   exit_sensor pulse. Aborted or timed-out passes give no count pulse.
//   Optional feature macro: LANE_ABORT_STATS_EN (8-bit saturating abort counter
//   on abort_count). When the macro is undefined, abort_count is tied to zero.
module parking_lane_detector #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int CNT_W           = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       beam_a,
    input  logic       beam_b,
    output logic       entry_sensor,
    output logic       exit_sensor,
    output logic       lane_busy,
    output logic       lane_fault,
    output logic [2:0] det_state,
    output logic [7:0] abort_count
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_IN_A     = 3'd1,
        S_IN_AB    = 3'd2,
        S_IN_B     = 3'd3,
        S_OUT_B    = 3'd4,
        S_OUT_BA   = 3'd5,
        S_OUT_A    = 3'd6,
        S_WAIT_CLR = 3'd7
    } state_t;

    logic             r_a_db;
    logic             r_b_db;
    logic [DB_W-1:0]  r_a_cnt;
    logic [DB_W-1:0]  r_b_cnt;
    logic [CNT_W-1:0] r_tmo;
    state_t           r_state;
    logic             r_entry;
    logic             r_exit;
    logic             r_fault;

    state_t           w_next;
    logic             w_entry;
    logic             w_exit;
    logic             w_fault;
    logic             w_timed;
    logic [1:0]       w_beams;

    assign w_beams = {r_a_db, r_b_db};
    assign w_timed = (r_state != S_IDLE) && (r_state != S_WAIT_CLR);

    // Beam A debounce: flip only after DEBOUNCE_CYCLES consecutive differing edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_db  <= 1'b0;
            r_a_cnt <= '0;
        end else if (beam_a == r_a_db) begin
            r_a_cnt <= '0;
        end else if (r_a_cnt == DB_LAST) begin
            r_a_db  <= beam_a;
            r_a_cnt <= '0;
        end else begin
            r_a_cnt <= r_a_cnt + 1'b1;
        end
    end

    // Beam B debounce: same filter as beam A.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_b_db  <= 1'b0;
            r_b_cnt <= '0;
        end else if (beam_b == r_b_db) begin
            r_b_cnt <= '0;
        end else if (r_b_cnt == DB_LAST) begin
            r_b_db  <= beam_b;
            r_b_cnt <= '0;
        end else begin
            r_b_cnt <= r_b_cnt + 1'b1;
        end
    end

    // State register and registered output pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_entry <= 1'b0;
            r_exit  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            r_entry <= w_entry;
            r_exit  <= w_exit;
            r_fault <= w_fault;
        end
    end

    // Timeout counter: restarts on every state change, runs only inside a pass.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo <= '0;
        end else if (w_next != r_state) begin
            r_tmo <= '0;
        end else if (w_timed) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    // Next-state decode on the debounced pair {A, B}; timeout overrides a stall.
    always_comb begin
        w_next  = r_state;
        w_entry = 1'b0;
        w_exit  = 1'b0;
        w_fault = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                case (w_beams)
                    2'b10:   w_next = S_IN_A;
                    2'b01:   w_next = S_OUT_B;
                    2'b11:   w_next = S_WAIT_CLR;
                    default: w_next = S_IDLE;
                endcase
            end
            S_IN_A: begin
                case (w_beams)
                    2'b11:   w_next = S_IN_AB;
                    2'b00:   w_next = S_IDLE;
                    default: w_next = S_IN_A;
                endcase
            end
            S_IN_AB: begin
                case (w_beams)
                    2'b01:   w_next = S_IN_B;
                    2'b10:   w_next = S_IN_A;
                    2'b00:   w_next = S_IDLE;
                    default: w_next = S_IN_AB;
                endcase
            end
            S_IN_B: begin
                case (w_beams)
                    2'b00: begin
                        w_next  = S_IDLE;
                        w_entry = 1'b1;
                    end
                    2'b11:   w_next = S_IN_AB;
                    default: w_next = S_IN_B;
                endcase
            end
            S_OUT_B: begin
                case (w_beams)
                    2'b11:   w_next = S_OUT_BA;
                    2'b00:   w_next = S_IDLE;
                    default: w_next = S_OUT_B;
                endcase
            end
            S_OUT_BA: begin
                case (w_beams)
                    2'b10:   w_next = S_OUT_A;
                    2'b01:   w_next = S_OUT_B;
                    2'b00:   w_next = S_IDLE;
                    default: w_next = S_OUT_BA;
                endcase
            end
            S_OUT_A: begin
                case (w_beams)
                    2'b00: begin
                        w_next = S_IDLE;
                        w_exit = 1'b1;
                    end
                    2'b11:   w_next = S_OUT_BA;
                    default: w_next = S_OUT_A;
                endcase
            end
            S_WAIT_CLR: begin
                if (w_beams == 2'b00) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if ((w_next == r_state) && w_timed && (r_tmo == TMO_LAST)) begin
            w_next  = S_WAIT_CLR;
            w_fault = 1'b1;
        end
    end

    assign entry_sensor = r_entry;
    assign exit_sensor  = r_exit;
    assign lane_fault   = r_fault;
    assign lane_busy    = (r_state != S_IDLE);
    assign det_state    = r_state;

`ifdef LANE_ABORT_STATS_EN
    logic       w_abort;
    logic [7:0] r_abort_cnt;

    // A clear lane seen in these states always ends the pass without a count.
    assign w_abort = (w_beams == 2'b00) &&
                     ((r_state == S_IN_A)  || (r_state == S_IN_AB) ||
                      (r_state == S_OUT_B) || (r_state == S_OUT_BA));

    // Saturating abort counter; timeouts are not aborts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_abort_cnt <= '0;
        end else if (w_abort && (r_abort_cnt != 8'hFF)) begin
            r_abort_cnt <= r_abort_cnt + 1'b1;
        end
    end

    assign abort_count = r_abort_cnt;
`else
    assign abort_count = '0;
`endif

endmodule

// File: tb/tb_parking_lane_detector.sv
// tb_parking_lane_detector
//   Directed bench for parking_lane_detector with DEBOUNCE_CYCLES=2 and
//   TIMEOUT_CYCLES=20. Expected abort_count follows LANE_ABORT_STATS_EN.
module tb_parking_lane_detector;

`ifdef LANE_ABORT_STATS_EN
    localparam logic [7:0] ABT = 8'd1;
`else
    localparam logic [7:0] ABT = 8'd0;
`endif

    logic       clk;
    logic       reset;
    logic       beam_a;
    logic       beam_b;
    logic       entry_sensor;
    logic       exit_sensor;
    logic       lane_busy;
    logic       lane_fault;
    logic [2:0] det_state;
    logic [7:0] abort_count;

    int n_checks;
    int n_fail;

    parking_lane_detector #(
        .DEBOUNCE_CYCLES(2),
        .TIMEOUT_CYCLES (20),
        .CNT_W          (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .beam_a      (beam_a),
        .beam_b      (beam_b),
        .entry_sensor(entry_sensor),
        .exit_sensor (exit_sensor),
        .lane_busy   (lane_busy),
        .lane_fault  (lane_fault),
        .det_state   (det_state),
        .abort_count (abort_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       a;
        logic       b;
        logic [2:0] st;
        logic       ent;
        logic       ext;
        logic [7:0] abt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic a, input logic b, input logic [2:0] st,
                                input logic ent, input logic ext, input logic [7:0] abt);
        vec_t v;
        v.a = a; v.b = b; v.st = st; v.ent = ent; v.ext = ext; v.abt = abt;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic ent,
                             input logic ext, input logic flt, input logic [7:0] abt);
        check({tag, " det_state"},    8'(det_state),    8'(st));
        check({tag, " entry_sensor"}, 8'(entry_sensor), 8'(ent));
        check({tag, " exit_sensor"},  8'(exit_sensor),  8'(ext));
        check({tag, " lane_busy"},    8'(lane_busy),    8'(st != 3'd0));
        check({tag, " lane_fault"},   8'(lane_fault),   8'(flt));
        check({tag, " abort_count"},  abort_count,      abt);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        beam_a   = 1'b0;
        beam_b   = 1'b0;

        // Clean entry: 10, 11, 01, 00 for 5 edges each.
        add(1,0,0,0,0,0); add(1,0,0,0,0,0); add(1,0,1,0,0,0); add(1,0,1,0,0,0); add(1,0,1,0,0,0);
        add(1,1,1,0,0,0); add(1,1,1,0,0,0); add(1,1,2,0,0,0); add(1,1,2,0,0,0); add(1,1,2,0,0,0);
        add(0,1,2,0,0,0); add(0,1,2,0,0,0); add(0,1,3,0,0,0); add(0,1,3,0,0,0); add(0,1,3,0,0,0);
        add(0,0,3,0,0,0); add(0,0,3,0,0,0); add(0,0,0,1,0,0); add(0,0,0,0,0,0); add(0,0,0,0,0,0);
        // Clean exit: 01, 11, 10, 00.
        add(0,1,0,0,0,0); add(0,1,0,0,0,0); add(0,1,4,0,0,0); add(0,1,4,0,0,0); add(0,1,4,0,0,0);
        add(1,1,4,0,0,0); add(1,1,4,0,0,0); add(1,1,5,0,0,0); add(1,1,5,0,0,0); add(1,1,5,0,0,0);
        add(1,0,5,0,0,0); add(1,0,5,0,0,0); add(1,0,6,0,0,0); add(1,0,6,0,0,0); add(1,0,6,0,0,0);
        add(0,0,6,0,0,0); add(0,0,6,0,0,0); add(0,0,0,0,1,0); add(0,0,0,0,0,0); add(0,0,0,0,0,0);
        // Glitch: one-edge beam_a pulse while idle.
        add(1,0,0,0,0,0); add(0,0,0,0,0,0); add(0,0,0,0,0,0); add(0,0,0,0,0,0);
        // Abort: 10, 11, 10, 00.
        add(1,0,0,0,0,0);   add(1,0,0,0,0,0);   add(1,0,1,0,0,0);   add(1,0,1,0,0,0); add(1,0,1,0,0,0);
        add(1,1,1,0,0,0);   add(1,1,1,0,0,0);   add(1,1,2,0,0,0);   add(1,1,2,0,0,0); add(1,1,2,0,0,0);
        add(1,0,2,0,0,0);   add(1,0,2,0,0,0);   add(1,0,1,0,0,0);   add(1,0,1,0,0,0); add(1,0,1,0,0,0);
        add(0,0,1,0,0,0);   add(0,0,1,0,0,0);   add(0,0,0,0,0,ABT); add(0,0,0,0,0,ABT);
        add(0,0,0,0,0,ABT);

        // Reset state.
        #2;
        check_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        #4;

        foreach (vecs[i]) begin
            beam_a = vecs[i].a;
            beam_b = vecs[i].b;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].ent, vecs[i].ext, 1'b0, vecs[i].abt);
        end

        // Both beams blocked from idle: ambiguous start, parks in WAIT_CLR, no fault.
        beam_a = 1'b1; beam_b = 1'b1;
        tick(); check_all("amb1", 3'd0, 1'b0, 1'b0, 1'b0, ABT);
        tick(); check_all("amb2", 3'd0, 1'b0, 1'b0, 1'b0, ABT);
        tick(); check_all("amb3", 3'd7, 1'b0, 1'b0, 1'b0, ABT);
        beam_a = 1'b0; beam_b = 1'b0;
        tick(); check_all("amb4", 3'd7, 1'b0, 1'b0, 1'b0, ABT);
        tick(); check_all("amb5", 3'd7, 1'b0, 1'b0, 1'b0, ABT);
        tick(); check_all("amb6", 3'd0, 1'b0, 1'b0, 1'b0, ABT);

        // Timeout: enter via A so the pass is live, then hold 11 for 25 edges.
        // IN_AB is reached on the 3rd edge of 11; 20 edges later the timeout fires.
        beam_a = 1'b1; beam_b = 1'b0;
        repeat (3) tick();
        check_all("tmo_in_a", 3'd1, 1'b0, 1'b0, 1'b0, ABT);
        beam_b = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            check_all($sformatf("tmo%0d", i), (i < 3) ? 3'd1 : (i < 23) ? 3'd2 : 3'd7,
                      1'b0, 1'b0, (i == 23), ABT);
        end
        beam_a = 1'b0; beam_b = 1'b0;
        tick(); check_all("tmo_clr1", 3'd7, 1'b0, 1'b0, 1'b0, ABT);
        tick(); check_all("tmo_clr2", 3'd7, 1'b0, 1'b0, 1'b0, ABT);
        tick(); check_all("tmo_clr3", 3'd0, 1'b0, 1'b0, 1'b0, ABT);

        // Reset mid-pass: reach IN_AB, then assert reset between edges.
        beam_a = 1'b1;
        repeat (3) tick();
        beam_b = 1'b1;
        repeat (3) tick();
        check_all("pre_rst", 3'd2, 1'b0, 1'b0, 1'b0, ABT);
        #3;
        reset  = 1'b0;
        beam_a = 1'b0;
        beam_b = 1'b0;
        #1;
        check_all("async_rst", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_all($sformatf("post_rst%0d", i), 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
